gpio_in_ctrl: RTL and testbench

Memory-mapped GPIO input responder: the read-side counterpart to the LSU's GPIO output registers. It synchronises and debounces `WIDTH` external input pins, detects qualified rising/falling edges into sticky status bits, and answers LSU-style load/store accesses in a small register window. It raises a level interrupt while any status bit is set.

---
 rtl/gpio_in_ctrl.sv | 140 ++++++++++++++
 tb/tb_gpio_in_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_ctrl.sv
// gpio_in_ctrl
// Memory-mapped GPIO input block. Each pin is synchronised and then
// debounced. Qualified rising and falling edges of the debounced value set
// sticky status flags. LSU-style word accesses reach a four-register window.
// The block raises a level interrupt while any status flag is set.
//
// Register window (byte offset from BASE_ADDR):
//   +0x0 DATA    read-only, debounced pin levels
//   +0x4 STATUS  sticky edge flags, write-1-to-clear
//   +0x8 RISE_EN rising-edge capture mask
//   +0xC FALL_EN falling-edge capture mask
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   addr_in    byte address from the LSU
//   data_in    write data
//   WE_in      write strobe
//   dtypes_in  access type (3'b010 = full word)
//   gpio_in    asynchronous external pins
//   data_out   registered read data for the addressed register
//   irq_out    OR of all status flags
module gpio_in_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int WIDTH           = 32,
  parameter int ADDRESS_SPACE   = 4096,
  parameter int BASE_ADDR       = 12'hEF8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(ADDRESS_SPACE)-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             WE_in,
  input  logic [2:0]                       dtypes_in,
  input  logic [WIDTH-1:0]                 gpio_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             irq_out
);

  localparam int AW = $clog2(ADDRESS_SPACE);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [AW-1:0] ADDR_DATA   = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(BASE_ADDR + 4);
  localparam logic [AW-1:0] ADDR_RISE   = AW'(BASE_ADDR + 8);
  localparam logic [AW-1:0] ADDR_FALL   = AW'(BASE_ADDR + 12);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    DT_WORD  = 3'b010;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [CW-1:0]    cnt [WIDTH];

  logic [WIDTH-1:0]      accept;
  logic [WIDTH-1:0]      set_evt;
  logic [WIDTH-1:0]      clr_mask;
  logic                  word_wr;
  logic [DATA_WIDTH-1:0] rd_data;

  // A pin is accepted on the cycle where it has already disagreed with
  // 'stable' for DEBOUNCE_CYCLES-1 counted cycles and still disagrees.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // The accepted new value equals sync2, so sync2 gives the edge direction.
  assign set_evt  = accept & ((sync2 & rise_en) | (~sync2 & fall_en));
  assign word_wr  = WE_in && (dtypes_in == DT_WORD);
  assign clr_mask = (word_wr && (addr_in == ADDR_STATUS)) ? data_in[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= gpio_in;
      sync2  <= sync1;
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] != stable[i]) && (cnt[i] != CNT_LAST)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // New edge events are ORed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      status  <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      status <= (status & ~clr_mask) | set_evt;
      if (word_wr && (addr_in == ADDR_RISE)) begin
        rise_en <= data_in[WIDTH-1:0];
      end
      if (word_wr && (addr_in == ADDR_FALL)) begin
        fall_en <= data_in[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr_in)
      ADDR_DATA:   rd_data = DATA_WIDTH'(stable);
      ADDR_STATUS: rd_data = DATA_WIDTH'(status);
      ADDR_RISE:   rd_data = DATA_WIDTH'(rise_en);
      ADDR_FALL:   rd_data = DATA_WIDTH'(fall_en);
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      data_out <= rd_data;
    end
  end

  assign irq_out = |status;

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// tb_gpio_in_ctrl
// Directed scoreboard bench for gpio_in_ctrl. Stimulus drives inputs on the
// falling edge and, for each checked read, queues the hand-computed data and
// interrupt level. A monitor pops one entry on every rising edge that samples
// a checked read and compares it shortly after that edge.
module tb_gpio_in_ctrl;

  localparam logic [11:0] A_DATA = 12'hEF8;
  localparam logic [11:0] A_STAT = 12'hEFC;
  localparam logic [11:0] A_RISE = 12'hF00;
  localparam logic [11:0] A_FALL = 12'hF04;
  localparam logic [11:0] A_UNM  = 12'hF08;
  localparam logic [2:0]  DT_W   = 3'b010;
  localparam logic [2:0]  DT_H   = 3'b001;
  localparam logic [2:0]  DT_B   = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr_in;
  logic [31:0] data_in;
  logic        WE_in;
  logic [2:0]  dtypes_in;
  logic [31:0] gpio_in;
  logic [31:0] data_out;
  logic        irq_out;

  always #5 clk = ~clk;

  gpio_in_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .WE_in     (WE_in),
    .dtypes_in (dtypes_in),
    .gpio_in   (gpio_in),
    .data_out  (data_out),
    .irq_out   (irq_out)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic rd_issue = 1'b0;
  int   tests    = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle per call: present the access, queue the expectation, wait.
  task automatic applyStimulus(input logic [11:0] a, input logic we, input logic [2:0] dt,
                               input logic [31:0] d, input logic chk, input string name,
                               input logic [31:0] exp_d, input logic exp_irq);
    exp_t e;
    addr_in   = a;
    WE_in     = we;
    dtypes_in = dt;
    data_in   = d;
    rd_issue  = chk;
    if (chk) begin
      e.name = name;
      e.data = exp_d;
      e.irq  = exp_irq;
      exp_q.push_back(e);
    end
    @(negedge clk);
    WE_in    = 1'b0;
    rd_issue = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [2:0] dt);
    applyStimulus(a, 1'b1, dt, d, 1'b0, "", 32'h0, 1'b0);
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp_d, input logic exp_irq);
    applyStimulus(a, 1'b0, DT_W, 32'h0, 1'b1, name, exp_d, exp_irq);
  endtask

  task automatic idle();
    applyStimulus(A_UNM, 1'b0, DT_W, 32'h0, 1'b0, "", 32'h0, 1'b0);
  endtask

  // The read sampled at this edge lands on data_out at this edge.
  always @(posedge clk) begin
    if (rd_issue) begin
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL scoreboard: read seen with no expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput({mon_e.name, " data"}, data_out, mon_e.data);
        checkOutput({mon_e.name, " irq"}, {31'b0, irq_out}, {31'b0, mon_e.irq});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    gpio_in   = 32'h0;
    addr_in   = A_UNM;
    data_in   = 32'h0;
    WE_in     = 1'b0;
    dtypes_in = DT_W;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state of all offsets.
    rd("rst_data", A_DATA, 32'h0, 1'b0);
    rd("rst_status", A_STAT, 32'h0, 1'b0);
    rd("rst_rise", A_RISE, 32'h0, 1'b0);
    rd("rst_fall", A_FALL, 32'h0, 1'b0);
    rd("rst_unmapped", A_UNM, 32'h0, 1'b0);

    // Rising edge on pin 0: stable and status update at edge 5 after the change.
    wr(A_RISE, 32'h1, DT_W);
    for (int j = 0; j < 7; j++) begin
      if (j == 0) gpio_in[0] = 1'b1;
      rd($sformatf("rise_lat_%0d", j), A_DATA, (j == 6) ? 32'h1 : 32'h0, (j >= 5));
    end
    rd("rise_status", A_STAT, 32'h1, 1'b1);
    wr(A_STAT, 32'h1, DT_W);
    rd("clear_status", A_STAT, 32'h0, 1'b0);

    // Three-cycle glitch on pin 3 is filtered.
    wr(A_RISE, 32'hFFFF_FFFF, DT_W);
    wr(A_FALL, 32'hFFFF_FFFF, DT_W);
    rd("en_rise", A_RISE, 32'hFFFF_FFFF, 1'b0);
    for (int j = 0; j < 11; j++) begin
      if (j == 0) gpio_in[3] = 1'b1;
      if (j == 3) gpio_in[3] = 1'b0;
      rd($sformatf("glitch_data_%0d", j), A_DATA, 32'h1, 1'b0);
    end
    rd("glitch_status", A_STAT, 32'h0, 1'b0);

    // Fall of pin 0 sets status; the later rise coincides with a clear write.
    gpio_in[0] = 1'b0;
    rd("fall_status0", A_STAT, 32'h0, 1'b0);
    for (int j = 1; j < 6; j++) begin
      rd($sformatf("fall_data_%0d", j), A_DATA, 32'h1, (j == 5));
    end
    gpio_in[0] = 1'b1;
    rd("fall_data_6", A_DATA, 32'h0, 1'b1);
    rd("fall_status", A_STAT, 32'h1, 1'b1);
    for (int j = 8; j < 11; j++) begin
      rd($sformatf("rerise_data_%0d", j), A_DATA, 32'h0, 1'b1);
    end
    wr(A_STAT, 32'h1, DT_W);
    rd("set_wins", A_STAT, 32'h1, 1'b1);
    wr(A_STAT, 32'h1, DT_W);
    rd("clear_after", A_STAT, 32'h0, 1'b0);
    rd("data_after", A_DATA, 32'h1, 1'b0);

    // Access qualification: partial writes, WE low, DATA and unmapped writes.
    wr(A_RISE, 32'h0, DT_W);
    wr(A_RISE, 32'hFF, DT_B);
    rd("byte_wr", A_RISE, 32'h0, 1'b0);
    wr(A_RISE, 32'hFFFF, DT_H);
    rd("half_wr", A_RISE, 32'h0, 1'b0);
    applyStimulus(A_RISE, 1'b0, DT_W, 32'hFF, 1'b1, "we_low", 32'h0, 1'b0);
    rd("we_low_after", A_RISE, 32'h0, 1'b0);
    wr(A_FALL, 32'h5A5A_0000, DT_W);
    rd("fall_rw", A_FALL, 32'h5A5A_0000, 1'b0);
    wr(A_DATA, 32'hFFFF_FFFF, DT_W);
    rd("data_ro", A_DATA, 32'h1, 1'b0);
    wr(A_UNM, 32'hFFFF_FFFF, DT_W);
    rd("unmapped_wr", A_UNM, 32'h0, 1'b0);

    // Quiet all pins (bit 0 not enabled for fall), enable rise on pin 1.
    gpio_in = 32'h0;
    wr(A_RISE, 32'h2, DT_W);
    repeat (7) idle();
    rd("quiet_data", A_DATA, 32'h0, 1'b0);
    rd("quiet_status", A_STAT, 32'h0, 1'b0);

    // Reset two cycles into a pin 1 debounce.
    gpio_in[1] = 1'b1;
    idle();
    idle();
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    rd("mid_rst_rise", A_RISE, 32'h0, 1'b0);
    rd("mid_rst_fall", A_FALL, 32'h0, 1'b0);
    rd("mid_rst_status", A_STAT, 32'h0, 1'b0);
    for (int j = 7; j < 11; j++) begin
      rd($sformatf("post_rst_data_%0d", j), A_DATA, (j == 10) ? 32'h2 : 32'h0, 1'b0);
    end
    rd("post_rst_status", A_STAT, 32'h0, 1'b0);

    idle();
    idle();
    if (exp_q.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
